// File: rtl/vga_timing_rx.sv
// VGA timing receiver: measures incoming hsync/vsync, locks onto the format and regenerates de/pix_x/pix_y/rgb_out.
// Optional per-frame CRC-16-CCITT of active pixels is built when FRAME_CRC_EN is defined.
module vga_timing_rx #(
    parameter logic [9:0] H_ACT_START = 10'd144,
    parameter logic [9:0] H_VALID     = 10'd640,
    parameter logic [9:0] V_ACT_START = 10'd35,
    parameter logic [9:0] V_VALID     = 10'd480,
    parameter logic [3:0] LOCK_FRAMES = 4'd2
) (
    input  logic        vga_clk,
    input  logic        sys_rst_n,
    input  logic        hsync,
    input  logic        vsync,
    input  logic [15:0] rgb_in,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic        de,
    output logic [15:0] rgb_out,
    output logic        locked,
    output logic [9:0]  h_total,
    output logic [9:0]  v_total,
    output logic        frame_start,
    output logic [15:0] frame_crc,
    output logic        crc_valid
);

    typedef enum logic [1:0] {SEARCH, CHECK, LOCKED} state_t;

    logic        hs_q, vs_q, hs_q2;
    logic [15:0] rgb_q, rgb_q2;
    logic [9:0]  cnt_h_q, cnt_v_q;
    logic        vs_line_q;
    logic [9:0]  h_total_q, v_total_q;
    state_t      state_q;
    logic [9:0]  h_ref_q, v_ref_q;
    logic        h_ref_ok_q, ref_ok_q;
    logic [3:0]  match_cnt_q;
    logic        locked_q;
    logic        de_q, frame_start_q;
    logic [9:0]  pix_x_q, pix_y_q;
    logic [15:0] rgb_out_q;

    logic        hs_rise, frame_rise, h_sat, v_sat, h_bad;
    logic [9:0]  h_meas, v_meas;
    logic [3:0]  match_nxt;
    logic        h_in, v_in, de_d;

    assign hs_rise    = hs_q & ~hs_q2;
    assign frame_rise = hs_rise & vs_q & ~vs_line_q;
    assign h_meas     = cnt_h_q + 10'd1;
    assign v_meas     = cnt_v_q + 10'd1;
    assign h_sat      = (cnt_h_q == 10'h3FF);
    assign v_sat      = (cnt_v_q == 10'h3FF);
    assign h_bad      = hs_rise & h_ref_ok_q & (h_meas != h_ref_q);
    assign match_nxt  = match_cnt_q + 4'd1;

    // Sum widened so the window end cannot wrap for any legal parameter set
    assign h_in = (cnt_h_q >= H_ACT_START) &&
                  ({1'b0, cnt_h_q} < ({1'b0, H_ACT_START} + {1'b0, H_VALID}));
    assign v_in = (cnt_v_q >= V_ACT_START) &&
                  ({1'b0, cnt_v_q} < ({1'b0, V_ACT_START} + {1'b0, V_VALID}));
    assign de_d = locked_q & h_in & v_in;

    always_ff @(posedge vga_clk) begin
        if (!sys_rst_n) begin
            hs_q      <= 1'b0;
            vs_q      <= 1'b0;
            hs_q2     <= 1'b0;
            rgb_q     <= 16'h0;
            rgb_q2    <= 16'h0;
            cnt_h_q   <= 10'd0;
            cnt_v_q   <= 10'd0;
            vs_line_q <= 1'b0;
            h_total_q <= 10'd0;
            v_total_q <= 10'd0;
        end else begin
            hs_q   <= hsync;
            vs_q   <= vsync;
            rgb_q  <= rgb_in;
            hs_q2  <= hs_q;
            rgb_q2 <= rgb_q;
            if (hs_rise) begin
                cnt_h_q   <= 10'd0;
                h_total_q <= h_meas;
                vs_line_q <= vs_q;
                if (frame_rise) begin
                    cnt_v_q   <= 10'd0;
                    v_total_q <= v_meas;
                end else if (!v_sat) begin
                    cnt_v_q <= cnt_v_q + 10'd1;
                end
            end else if (!h_sat) begin
                cnt_h_q <= cnt_h_q + 10'd1;
            end
        end
    end

    always_ff @(posedge vga_clk) begin
        if (!sys_rst_n) begin
            state_q     <= SEARCH;
            h_ref_q     <= 10'd0;
            v_ref_q     <= 10'd0;
            h_ref_ok_q  <= 1'b0;
            ref_ok_q    <= 1'b0;
            match_cnt_q <= 4'd0;
            locked_q    <= 1'b0;
        end else begin
            locked_q <= (state_q == LOCKED);
            case (state_q)
                SEARCH: begin
                    if (frame_rise) begin
                        state_q     <= CHECK;
                        match_cnt_q <= 4'd0;
                        ref_ok_q    <= 1'b0;
                        h_ref_ok_q  <= 1'b0;
                    end
                end
                CHECK: begin
                    if (h_sat || h_bad) begin
                        state_q <= SEARCH;
                    end else begin
                        if (hs_rise && !h_ref_ok_q) begin
                            h_ref_q    <= h_meas;
                            h_ref_ok_q <= 1'b1;
                        end
                        // First frame in CHECK only learns the reference frame length
                        if (frame_rise) begin
                            if (!ref_ok_q) begin
                                v_ref_q  <= v_meas;
                                ref_ok_q <= 1'b1;
                            end else if (v_meas != v_ref_q) begin
                                state_q <= SEARCH;
                            end else begin
                                match_cnt_q <= match_nxt;
                                if (match_nxt >= LOCK_FRAMES) state_q <= LOCKED;
                            end
                        end
                    end
                end
                LOCKED: begin
                    if (h_sat || v_sat ||
                        (hs_rise && (h_meas != h_ref_q)) ||
                        (frame_rise && (v_meas != v_ref_q)))
                        state_q <= SEARCH;
                end
                default: state_q <= SEARCH;
            endcase
        end
    end

    always_ff @(posedge vga_clk) begin
        if (!sys_rst_n) begin
            de_q          <= 1'b0;
            pix_x_q       <= 10'h3FF;
            pix_y_q       <= 10'h3FF;
            rgb_out_q     <= 16'h0;
            frame_start_q <= 1'b0;
        end else begin
            de_q          <= de_d;
            pix_x_q       <= de_d ? (cnt_h_q - H_ACT_START) : 10'h3FF;
            pix_y_q       <= de_d ? (cnt_v_q - V_ACT_START) : 10'h3FF;
            rgb_out_q     <= de_d ? rgb_q2 : 16'h0;
            frame_start_q <= frame_rise;
        end
    end

    assign pix_x       = pix_x_q;
    assign pix_y       = pix_y_q;
    assign de          = de_q;
    assign rgb_out     = rgb_out_q;
    assign locked      = locked_q;
    assign h_total     = h_total_q;
    assign v_total     = v_total_q;
    assign frame_start = frame_start_q;

`ifdef FRAME_CRC_EN
    logic [15:0] crc_acc_q, frame_crc_q;
    logic        crc_valid_q, crc_whole_q;

    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic [15:0] data);
        logic [15:0] c;
        logic        fb;
        c = crc;
        for (int i = 15; i >= 0; i--) begin
            fb = c[15] ^ data[i];
            c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
        end
        return c;
    endfunction

    // crc_whole_q remembers whether lock held since the last frame start
    always_ff @(posedge vga_clk) begin
        if (!sys_rst_n) begin
            crc_acc_q   <= 16'hFFFF;
            frame_crc_q <= 16'h0;
            crc_valid_q <= 1'b0;
            crc_whole_q <= 1'b0;
        end else begin
            crc_valid_q <= 1'b0;
            if (frame_start_q) begin
                if (crc_whole_q && locked_q) begin
                    frame_crc_q <= crc_acc_q;
                    crc_valid_q <= 1'b1;
                end
                crc_acc_q   <= 16'hFFFF;
                crc_whole_q <= locked_q;
            end else if (!locked_q) begin
                crc_acc_q   <= 16'hFFFF;
                crc_whole_q <= 1'b0;
            end else if (de_q) begin
                crc_acc_q <= crc16_step(crc_acc_q, rgb_out_q);
            end
        end
    end

    assign frame_crc = frame_crc_q;
    assign crc_valid = crc_valid_q;
`else
    assign frame_crc = 16'h0;
    assign crc_valid = 1'b0;
`endif

endmodule

// File: tb/tb_vga_timing_rx.sv
// Scoreboard bench for vga_timing_rx on a reduced 20x10 raster (active window 8x4 at x=6, y=2).
// Driver pushes expected pixels, frame starts and CRCs; a negedge monitor pops and compares.
module tb_vga_timing_rx;
    localparam int HT  = 20;
    localparam int VT  = 10;
    localparam int HSW = 3;
    localparam int VSW = 2;
    localparam int HA  = 6;
    localparam int HV  = 8;
    localparam int VA  = 2;
    localparam int VV  = 4;

    logic        vga_clk   = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        hsync     = 1'b0;
    logic        vsync     = 1'b0;
    logic [15:0] rgb_in    = 16'h0;
    logic [9:0]  pix_x, pix_y, h_total, v_total;
    logic        de, locked, frame_start, crc_valid;
    logic [15:0] rgb_out, frame_crc;

    vga_timing_rx #(
        .H_ACT_START(10'(HA)),
        .H_VALID    (10'(HV)),
        .V_ACT_START(10'(VA)),
        .V_VALID    (10'(VV)),
        .LOCK_FRAMES(4'd2)
    ) dut (
        .vga_clk    (vga_clk),
        .sys_rst_n  (sys_rst_n),
        .hsync      (hsync),
        .vsync      (vsync),
        .rgb_in     (rgb_in),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .de         (de),
        .rgb_out    (rgb_out),
        .locked     (locked),
        .h_total    (h_total),
        .v_total    (v_total),
        .frame_start(frame_start),
        .frame_crc  (frame_crc),
        .crc_valid  (crc_valid)
    );

    always #20 vga_clk = ~vga_clk;

    int cyc = 0;
    always @(posedge vga_clk) cyc <= cyc + 1;

    typedef struct { int cyc; logic [9:0] x; logic [9:0] y; logic [15:0] rgb; } pix_t;
    typedef struct { int cyc; logic [15:0] crc; } crc_t;

    pix_t        pix_q[$];
    int          fs_q[$];
    crc_t        crc_q[$];
    int          errors    = 0;
    int          checks    = 0;
    bit          run_mon   = 1'b0;
    bit          prev_full = 1'b0;
    logic [15:0] model_acc = 16'hFFFF;
    int          frame_no  = 0;
`ifdef FRAME_CRC_EN
    logic [15:0] last_crc  = 16'h0;
`endif

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Whole word XORed in, then 16 shifts: same result as feeding the word MSB-first
    function automatic logic [15:0] crc_model(input logic [15:0] crc, input logic [15:0] d);
        logic [15:0] c;
        c = crc ^ d;
        for (int i = 0; i < 16; i++) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
        return c;
    endfunction

    function automatic logic [15:0] pix_val(input int h, input int v);
        if (h == HA && v == VA) return 16'hF800;
        return 16'((v << 10) | h);
    endfunction

    task automatic drive(input logic hs, input logic vs, input logic [15:0] d, input logic rst_n);
        @(posedge vga_clk);
        #1;
        hsync     = hs;
        vsync     = vs;
        rgb_in    = d;
        sys_rst_n = rst_n;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_locked"},      48'(locked),      48'(0));
        check({tag, "_de"},          48'(de),          48'(0));
        check({tag, "_pix_x"},       48'(pix_x),       48'(10'h3FF));
        check({tag, "_pix_y"},       48'(pix_y),       48'(10'h3FF));
        check({tag, "_rgb_out"},     48'(rgb_out),     48'(0));
        check({tag, "_h_total"},     48'(h_total),     48'(0));
        check({tag, "_v_total"},     48'(v_total),     48'(0));
        check({tag, "_frame_start"}, 48'(frame_start), 48'(0));
        check({tag, "_frame_crc"},   48'(frame_crc),   48'(0));
        check({tag, "_crc_valid"},   48'(crc_valid),   48'(0));
    endtask

    task automatic gen_line(input int v, input int len, input bit lock_exp, input int rst_col);
        logic [15:0] d;
        pix_t        p;
`ifdef FRAME_CRC_EN
        crc_t        c;
`endif
        for (int h = 0; h < len; h++) begin
            d = pix_val(h, v);
            drive(h < HSW, v < VSW, d, h != rst_col);
            if (h == 0 && v == 0) begin
                fs_q.push_back(cyc + 2);
                if (prev_full) begin
`ifdef FRAME_CRC_EN
                    c.cyc = cyc + 3;
                    c.crc = model_acc;
                    crc_q.push_back(c);
                    last_crc = model_acc;
`endif
                end
                model_acc = 16'hFFFF;
            end
            if (lock_exp && h >= HA && h < HA + HV && v >= VA && v < VA + VV) begin
                p.cyc = cyc + 3;
                p.x   = 10'(h - HA);
                p.y   = 10'(v - VA);
                p.rgb = d;
                pix_q.push_back(p);
                model_acc = crc_model(model_acc, d);
            end
            if (rst_col >= 0 && h == rst_col + 1) check_reset("midframe_rst");
        end
    endtask

    task automatic gen_frame(input bit lock_exp, input bit full, input int stretch_v, input int rst_v);
        $display("frame %0d: lock_exp=%0d crc_frame=%0d stretch_line=%0d reset_line=%0d",
                 frame_no, lock_exp, full, stretch_v, rst_v);
        for (int v = 0; v < VT; v++)
            gen_line(v, (v == stretch_v) ? HT + 1 : HT, lock_exp, (v == rst_v) ? 10 : -1);
        prev_full = full;
        frame_no++;
    endtask

    always @(negedge vga_clk) begin : monitor
        pix_t e;
        crc_t ce;
        if (run_mon) begin
            if (pix_q.size() > 0 && pix_q[0].cyc == cyc) begin
                e = pix_q.pop_front();
                check("de",      48'(de),      48'(1));
                check("pix_x",   48'(pix_x),   48'(e.x));
                check("pix_y",   48'(pix_y),   48'(e.y));
                check("rgb_out", 48'(rgb_out), 48'(e.rgb));
            end else begin
                check("idle_out", 48'({de, pix_x, pix_y, rgb_out}),
                      48'({1'b0, 10'h3FF, 10'h3FF, 16'h0}));
            end
            if (fs_q.size() > 0 && fs_q[0] == cyc) begin
                void'(fs_q.pop_front());
                check("frame_start", 48'(frame_start), 48'(1));
            end else begin
                check("frame_start_idle", 48'(frame_start), 48'(0));
            end
            if (crc_q.size() > 0 && crc_q[0].cyc == cyc) begin
                ce = crc_q.pop_front();
                check("crc_valid", 48'(crc_valid), 48'(1));
                check("frame_crc", 48'(frame_crc), 48'(ce.crc));
            end else begin
                check("crc_valid_idle", 48'(crc_valid), 48'(0));
            end
        end
    end

    initial begin
        repeat (3) drive(1'b0, 1'b0, 16'h0, 1'b0);
        check_reset("reset");
        run_mon = 1'b1;

        // F1..F4 lock sequence, then one CRC-qualified frame
        repeat (3) gen_frame(1'b0, 1'b0, -1, -1);
        gen_frame(1'b1, 1'b0, -1, -1);
        gen_frame(1'b1, 1'b1, -1, -1);
        check("lock_locked",  48'(locked),  48'(1));
        check("lock_h_total", 48'(h_total), 48'(HT));
        check("lock_v_total", 48'(v_total), 48'(VT));

        // Line 7 stretched by one clock drops lock
        gen_frame(1'b1, 1'b0, 7, -1);
        check("stretch_locked", 48'(locked), 48'(0));
        repeat (3) gen_frame(1'b0, 1'b0, -1, -1);
        gen_frame(1'b1, 1'b0, -1, -1);
        gen_frame(1'b1, 1'b1, -1, -1);
        gen_frame(1'b1, 1'b0, -1, -1);
        check("relock1_locked", 48'(locked), 48'(1));

        // hsync held low until cnt_h saturates
        repeat (1200) drive(1'b0, 1'b0, 16'h1234, 1'b1);
        check("hold_locked", 48'(locked), 48'(0));
        check("hold_de",     48'(de),     48'(0));
        repeat (3) gen_frame(1'b0, 1'b0, -1, -1);
        gen_frame(1'b1, 1'b0, -1, -1);

        // One-cycle reset on line 7
        gen_frame(1'b1, 1'b0, -1, 7);
        repeat (3) gen_frame(1'b0, 1'b0, -1, -1);
        gen_frame(1'b1, 1'b0, -1, -1);
        gen_frame(1'b1, 1'b1, -1, -1);
        gen_frame(1'b1, 1'b0, -1, -1);
        check("relock2_locked",  48'(locked),  48'(1));
        check("relock2_h_total", 48'(h_total), 48'(HT));
        check("relock2_v_total", 48'(v_total), 48'(VT));

        repeat (4) drive(1'b0, 1'b0, 16'h0, 1'b1);
`ifdef FRAME_CRC_EN
        check("frame_crc_final", 48'(frame_crc), 48'(last_crc));
`else
        check("frame_crc_zero",  48'(frame_crc), 48'(0));
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
